// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and frame-tracking types for the scan bus encoder and capture.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;

  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;

  localparam logic [3:0] INVALID_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    StEmpty,
    StCand,
    StLocked
  } frame_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to BCD nibble decoder; unknown patterns map to INVALID_DIGIT.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble
);

  always_comb begin
    nibble = INVALID_DIGIT;
    case (seg)
      SEG_0:   nibble = 4'd0;
      SEG_1:   nibble = 4'd1;
      SEG_2:   nibble = 4'd2;
      SEG_3:   nibble = 4'd3;
      SEG_4:   nibble = 4'd4;
      SEG_5:   nibble = 4'd5;
      SEG_6:   nibble = 4'd6;
      SEG_7:   nibble = 4'd7;
      SEG_8:   nibble = 4'd8;
      SEG_9:   nibble = 4'd9;
      default: nibble = INVALID_DIGIT;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Samples a multiplexed four-digit seven-segment bus, decodes each digit and publishes the
// 16-bit value once two consecutive identical frames have been seen.
module seven_seg_capture
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned TIMEOUT       = 262143
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] bcd,
  output logic        valid,
  output logic        err,
  output logic        stale
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_HIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_HIT     = TW'(TIMEOUT - 1);

  logic [3:0]    an_q;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] stale_cnt_q, stale_cnt_d;
  logic [15:0]   slots_q, slots_d, cand_q, cand_d, bcd_q, bcd_d;
  logic [3:0]    seen_q, seen_d;
  logic          frame_done_q, frame_done_d;
  logic          valid_q, valid_d, err_q, err_d, stale_q, stale_d;
  frame_state_e  state_q, state_d;

  logic       an_legal, stable, sample, timeout, slots_bad;
  logic [1:0] idx;
  logic [3:0] onehot, nibble, seen_base;

  seg7_decode u_decode (
    .seg    (seg),
    .nibble (nibble)
  );

  always_comb begin
    an_legal = 1'b1;
    idx      = 2'd0;
    case (an)
      AN_D0:   idx = 2'd0;
      AN_D1:   idx = 2'd1;
      AN_D2:   idx = 2'd2;
      AN_D3:   idx = 2'd3;
      default: an_legal = 1'b0;
    endcase
  end

  assign onehot  = 4'b0001 << idx;
  assign stable  = an_legal && (an == an_q);
  // Counter saturates one past the hit value, so each dwell yields exactly one sample.
  assign sample  = stable && (settle_q == SETTLE_HIT);
  assign timeout = !sample && (stale_cnt_q == TO_HIT);

  always_comb begin
    slots_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (slots_q[4*i +: 4] == INVALID_DIGIT) slots_bad = 1'b1;
    end
  end

  always_comb begin
    settle_d = '0;
    if (stable) settle_d = (settle_q == SETTLE_MAX) ? settle_q : settle_q + SW'(1);

    stale_cnt_d = stale_cnt_q;
    if (sample) stale_cnt_d = '0;
    else if (stale_cnt_q != TO_MAX) stale_cnt_d = stale_cnt_q + TW'(1);

    slots_d = slots_q;
    if (sample) slots_d[{idx, 2'b00} +: 4] = nibble;

    seen_base    = frame_done_q ? 4'b0000 : seen_q;
    seen_d       = sample ? (seen_base | onehot) : seen_base;
    frame_done_d = sample && ((seen_base | onehot) == 4'b1111);
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    err_d   = err_q;
    stale_d = stale_q;
    if (frame_done_q) begin
      cand_d = slots_q;
      if (state_q != StEmpty && slots_q == cand_q) begin
        state_d = StLocked;
        bcd_d   = slots_q;
        valid_d = 1'b1;
        err_d   = slots_bad;
        stale_d = 1'b0;
      end else begin
        state_d = StCand;
      end
    end
    if (timeout) begin
      state_d = StEmpty;
      stale_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q         <= 4'b1111;
      settle_q     <= '0;
      stale_cnt_q  <= '0;
      slots_q      <= '0;
      cand_q       <= '0;
      bcd_q        <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      stale_q      <= 1'b0;
      state_q      <= StEmpty;
    end else begin
      an_q         <= an;
      settle_q     <= settle_d;
      stale_cnt_q  <= stale_cnt_d;
      slots_q      <= slots_d;
      cand_q       <= cand_d;
      bcd_q        <= bcd_d;
      seen_q       <= timeout ? 4'b0000 : seen_d;
      frame_done_q <= frame_done_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      stale_q      <= stale_d;
      state_q      <= state_d;
    end
  end

  assign bcd   = bcd_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign stale = stale_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scan scenarios plus randomized scans against a
// frame-level reference model.
module tb_seven_seg_capture;

  localparam int unsigned SETTLE = 16;
  localparam int unsigned TMO    = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bcd;
  logic        valid, err, stale;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;

  seven_seg_capture #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT       (TMO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .seg   (seg),
    .an    (an),
    .bcd   (bcd),
    .valid (valid),
    .err   (err),
    .stale (stale)
  );

  always #5 clk = ~clk;

  logic [6:0] enc [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  logic [6:0] dash = 7'b0000001;

  // Reference model state
  int          m_run, m_idle;
  logic [3:0]  m_prev_an, m_seen;
  logic [15:0] m_slots, m_cand, m_bcd;
  bit          m_cand_valid, m_pending, m_valid, m_err, m_stale;

  function automatic logic [3:0] ref_decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (enc[i] == s) return 4'(i);
    return 4'hF;
  endfunction

  function automatic bit has_f(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] == 4'hF) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] a, input logic [6:0] s);
    int  d;
    bit  legal;
    logic [3:0] code;
    if (r) begin
      m_run = 0; m_idle = 0; m_prev_an = 4'hF; m_seen = '0; m_slots = '0; m_cand = '0;
      m_bcd = '0; m_cand_valid = 0; m_pending = 0; m_valid = 0; m_err = 0; m_stale = 0;
      return;
    end
    m_valid = 0;
    if (m_pending) begin
      m_pending = 0;
      m_seen = '0;
      if (m_cand_valid && m_slots == m_cand) begin
        m_bcd = m_slots; m_valid = 1; m_err = has_f(m_slots); m_stale = 0;
      end
      m_cand = m_slots;
      m_cand_valid = 1;
    end
    legal = 0; d = 0;
    for (int i = 0; i < 4; i++) begin
      code = ~(4'b0001 << i);
      if (a == code) begin legal = 1; d = i; end
    end
    if (!legal) m_run = 0;
    else if (a == m_prev_an) m_run++;
    else m_run = 1;
    m_prev_an = a;
    // A digit is captured once its code has been present for SETTLE+1 cycles inclusive.
    if (legal && m_run == SETTLE + 1) begin
      m_slots[4*d +: 4] = ref_decode(s);
      m_seen[d] = 1'b1;
      m_idle = 0;
      if (m_seen == 4'hF) m_pending = 1;
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        m_stale = 1; m_seen = '0; m_cand_valid = 0;
      end
    end
  endtask

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic [3:0] a, input logic [6:0] s);
    rst = r; an = a; seg = s;
    @(posedge clk);
    model_step(r, a, s);
    #1;
    if (valid === 1'b1) vcnt++;
    check_vec("outputs", {13'd0, bcd, valid, err, stale},
              {13'd0, m_bcd, m_valid, m_err, m_stale});
  endtask

  task automatic scan_digit(input int d, input logic [6:0] s, input int dwell);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    repeat (dwell) tick(1'b0, a, s);
  endtask

  task automatic scan_frame(input logic [15:0] v);
    for (int d = 0; d < 4; d++) scan_digit(d, enc[v[4*d +: 4]], 40);
  endtask

  initial begin
    logic [15:0] rv;
    int reps, start, dw;
    logic [6:0] s;

    // Reset and first lock on 0x1234
    repeat (3) tick(1'b1, 4'hF, 7'd0);
    check_vec("reset_outputs", {13'd0, bcd, valid, err, stale}, 32'd0);
    vcnt = 0;
    scan_frame(16'h1234);
    check_vec("no_valid_frame1", vcnt, 0);
    scan_frame(16'h1234);
    check_vec("commit_frame2_bcd", {16'd0, bcd}, 32'h1234);
    check_vec("commit_frame2_cnt", vcnt, 1);
    scan_frame(16'h1234);
    scan_frame(16'h1234);
    check_vec("valid_per_frame", vcnt, 3);

    // Mid-scan switch to 0x5678
    vcnt = 0;
    scan_digit(0, enc[4], 40);
    scan_digit(1, enc[3], 40);
    scan_digit(2, enc[6], 40);
    scan_digit(3, enc[5], 40);
    scan_frame(16'h5678);
    check_vec("switch_hold_bcd", {16'd0, bcd}, 32'h1234);
    check_vec("switch_no_valid", vcnt, 0);
    scan_frame(16'h5678);
    check_vec("switch_commit_bcd", {16'd0, bcd}, 32'h5678);

    // Short glitch dwell on digit 2
    scan_frame(16'h1234);
    scan_frame(16'h1234);
    vcnt = 0;
    scan_digit(0, enc[4], 40);
    scan_digit(1, enc[3], 40);
    scan_digit(2, enc[2], 10);
    scan_digit(3, enc[1], 40);
    scan_frame(16'h1234);
    scan_frame(16'h1234);
    check_vec("glitch_bcd", {16'd0, bcd}, 32'h1234);
    check_vec("glitch_commits", vcnt, 2);

    // Dash on digit 2
    repeat (3) begin
      scan_digit(0, enc[4], 40);
      scan_digit(1, enc[3], 40);
      scan_digit(2, dash, 40);
      scan_digit(3, enc[1], 40);
    end
    check_vec("dash_bcd", {16'd0, bcd}, 32'h1F34);
    check_vec("dash_err", {31'd0, err}, 32'd1);
    repeat (3) scan_frame(16'h1234);
    check_vec("clean_bcd", {16'd0, bcd}, 32'h1234);
    check_vec("clean_err", {31'd0, err}, 32'd0);

    // Idle bus goes stale
    repeat (TMO) tick(1'b0, 4'hF, 7'd0);
    check_vec("stale_set", {31'd0, stale}, 32'd1);
    check_vec("stale_bcd_hold", {16'd0, bcd}, 32'h1234);
    vcnt = 0;
    scan_frame(16'h1234);
    check_vec("stale_resume_no_valid", vcnt, 0);
    check_vec("stale_still_set", {31'd0, stale}, 32'd1);
    scan_frame(16'h1234);
    check_vec("stale_cleared", {31'd0, stale}, 32'd0);
    check_vec("stale_resume_commit", vcnt, 1);

    // Reset mid-frame
    scan_digit(0, enc[4], 40);
    scan_digit(1, enc[3], 40);
    repeat (2) tick(1'b1, 4'hF, 7'd0);
    check_vec("midreset_outputs", {13'd0, bcd, valid, err, stale}, 32'd0);
    vcnt = 0;
    scan_frame(16'h1234);
    check_vec("midreset_no_valid", vcnt, 0);
    scan_frame(16'h1234);
    check_vec("midreset_commit_bcd", {16'd0, bcd}, 32'h1234);
    check_vec("midreset_commit_cnt", vcnt, 1);

    // Randomized scans: random values, dwells, start digit, bad patterns and idle gaps
    for (int k = 0; k < 15; k++) begin
      for (int d = 0; d < 4; d++) rv[4*d +: 4] = 4'($urandom_range(0, 9));
      reps  = int'($urandom_range(1, 3));
      start = int'($urandom_range(0, 3));
      for (int r = 0; r < reps; r++) begin
        for (int j = 0; j < 4; j++) begin
          int d;
          d  = (start + j) % 4;
          dw = int'($urandom_range(8, 45));
          s  = enc[rv[4*d +: 4]];
          if ($urandom_range(0, 19) == 0) s = 7'($urandom);
          scan_digit(d, s, dw);
          repeat ($urandom_range(0, 3)) tick(1'b0, 4'hF, 7'd0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Scan-side receiver for the multiplexed four-digit seven-segment bus. It watches the active-low anode strobes and the active-high segment lines, samples each digit once its anode has settled, and decodes the pattern back to a 4-bit BCD nibble. It reassembles the 16-bit value and publishes it only after two consecutive identical frames. It sits beside the display driver as a readback and self-check path, and is also used as the bench monitor.

## Interface

- `SETTLE_CYCLES`, default 16: consecutive cycles an anode code must be stable before its digit is sampled; legal range ≥2.
- `TIMEOUT`, default 262143: cycles with no digit sample before the bus is declared stale.

- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `seg` input, 7 bits: segments a..g in bits [6:0], active-high.
- `an` input, 4 bits: digit enables, active-low, one-hot-low; bit i selects digit i (bit 0 is the least-significant digit).
- `bcd` output, 16 bits: last confirmed value; digit i is in `bcd[4i+3:4i]`.
- `valid` output, 1 bit: one-cycle pulse on each confirmed frame commit.
- `err` output, 1 bit: the last committed frame contained at least one undecodable digit.
- `stale` output, 1 bit: no scan activity for `TIMEOUT` cycles.

## Operation

- Decode table, pattern to nibble:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4
  - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9
  - any other pattern, including dash 0000001, →4'hF (invalid).
- Legal anode codes: 1110, 1101, 1011, 0111. Any other code (1111, multiple lows) is idle.
  - Idle holds the settle counter at 0.
  - Idle takes no sample.
- Settle tracking:
  - `an_q` registers the previous `an`.
  - If `an != an_q`, or `an` is idle, the settle counter clears to 0.
  - Otherwise the settle counter increments, saturating at `SETTLE_CYCLES`.
- Sample event: fires in the cycle the counter reaches `SETTLE_CYCLES-1` with a legal code. It fires exactly once per dwell.
  - Writes the decoded nibble into `slot[i]`.
  - Sets `seen[i]`.
  - Clears the stale counter.
  - A repeated sample of a digit already seen overwrites that slot.
- Frame complete: `seen==4'b1111` after a sample. On the following cycle:
  - `seen` clears.
  - If `cand_valid` and `slots==cand`: `bcd<=slots`, `valid` pulses, `err` is set to (any nibble == F), `stale` clears.
  - Otherwise: `cand<=slots`, `cand_valid<=1`, and there is no commit.
  - In both cases `cand` is refreshed with `slots`, so steady scanning commits once per frame.
- Stale handling: a stale counter increments every cycle without a sample. When it reaches `TIMEOUT`:
  - `stale<=1`.
  - `seen` and `cand_valid` clear.
  - The counter saturates.
  - `bcd` and `err` hold.
- Frame FSM states:
  - EMPTY (no candidate)
  - CAND (candidate held, collecting the confirming frame)
  - LOCKED (committed, tracking)
- FSM transitions:
  - EMPTY→CAND on the first complete frame.
  - CAND→LOCKED on a match.
  - CAND→CAND on a mismatch (candidate replaced).
  - LOCKED stays LOCKED on a match (`valid` pulses).
  - LOCKED→CAND on a mismatch.
  - Any state →EMPTY on timeout.
- `dp` is not observed.

## Timing

- Reset values:
  - `bcd`=0, `valid`=0, `err`=0, `stale`=0.
  - `seen`=0, `cand_valid`=0, FSM=EMPTY.
  - All counters 0; `an_q`=4'b1111.
- Sample latency: a sample is taken `SETTLE_CYCLES` cycles after the first cycle of a new stable code (`an_q` adds one cycle).
- Commit latency: `bcd` and `valid` update 1 cycle after the sample that completes the confirming frame.
- A sample and a timeout in the same cycle: the sample wins and the stale counter clears.
- A reset asserted mid-frame discards all partial state. After release, two full frames are again required before a commit.
- A frame is any set of four distinct digit samples. Scan order is not checked.

## Structure

- `seg7_pkg` holds:
  - the ten segment pattern constants and the dash constant
  - the four anode codes
  - the `INVALID_DIGIT` value 4'hF
  - the frame FSM state enum.
- Sub-module `seg7_decode`: combinational, 7-bit pattern to 4-bit nibble. It shares the package constants with the driver's encoder so the two tables cannot diverge.
- The top level holds the settle counter, slots, candidate, frame FSM and stale counter.

## Test plan

Stimulus comes from a driver model with a 40-cycle dwell per digit, `SETTLE_CYCLES`=16 and `TIMEOUT`=1000.

- Reset then scan 0x1234: there is no `valid` after frame 1. Frame 2 commits `bcd`=16'h1234 with a single `valid` pulse, and `valid` pulses once per frame after that.
- Switch to 0x5678 mid-scan: `bcd` stays 16'h1234 through the mixed frame and the first pure frame, then commits 16'h5678 on the second pure frame.
- Glitch dwell of 10 cycles on digit 2, inside an otherwise steady 0x1234 scan: no sample is taken for that dwell, and 0x1234 is still committed on later frames.
- Dash 0000001 on digit 2 with 0x1234 elsewhere: after two frames `bcd`=16'h1F34 and `err`=1. A later clean 0x1234 confirms and clears `err`.
- Hold `an`=1111 for 1000 cycles: `stale`=1 and `bcd` holds. On resuming, the first frame gives no commit, and the second commits and clears `stale`.
- Assert `rst` after 2 digits of a frame: all outputs return to 0, and the next commit needs two full frames after release.
